// File: rtl/irq_controller.sv
// Prioritised external-interrupt front end: synchronises and edge-detects source lines,
// holds them as pending, masks them and hands one at a time to the core via ExtIRQ/ExtIAck.
module irq_controller #(
  parameter int NSRC = 8,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cfg_we,
  input  logic [NSRC-1:0] cfg_mask,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  // state    | meaning
  // IDLE     | no request outstanding, looking for an eligible source
  // REQ      | ExtIRQ high, irq_id frozen until the core acknowledges
  // WAIT_REL | request retired, waiting for ExtIAck to drop
  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;

  state_t          state, state_nx;
  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] evt, elig, clr;
  logic [IDW-1:0]  sel, id_nx;
  logic            irq_nx;

  assign evt  = s2 & ~s3;
  assign elig = pending & mask;

  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = IDW'(i);
    end
  end

  always_comb begin
    state_nx = state;
    irq_nx   = ExtIRQ;
    id_nx    = irq_id;
    clr      = '0;
    case (state)
      IDLE: begin
        if (|elig) begin
          id_nx    = sel;
          irq_nx   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (ExtIAck) begin
          clr[irq_id] = 1'b1;
          irq_nx      = 1'b0;
          state_nx    = WAIT_REL;
        end
      end
      WAIT_REL: begin
        irq_nx = 1'b0;
        if (!ExtIAck) state_nx = IDLE;
      end
      default: begin
        irq_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      mask    <= '0;
      state   <= IDLE;
      ExtIRQ  <= 1'b0;
      irq_id  <= '0;
    end else begin
      s1      <= irq_src;
      s2      <= s1;
      s3      <= s2;
      // a fresh event beats a same-cycle acknowledge clear
      pending <= (pending & ~clr) | evt;
      if (cfg_we) mask <= cfg_mask;
      state   <= state_nx;
      ExtIRQ  <= irq_nx;
      irq_id  <= id_nx;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: expected service IDs are queued as sources
// are pulsed and compared when ExtIRQ is presented.
module tb_irq_controller;

  localparam int NSRC = 8;
  localparam int IDW  = $clog2(NSRC);

  logic            CLOCK_50 = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic            cfg_we;
  logic [NSRC-1:0] cfg_mask;
  logic            ExtIAck;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  irq_controller #(.NSRC(NSRC), .IDW(IDW)) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .irq_src (irq_src),
    .cfg_we  (cfg_we),
    .cfg_mask(cfg_mask),
    .ExtIAck (ExtIAck),
    .ExtIRQ  (ExtIRQ),
    .irq_id  (irq_id),
    .pending (pending),
    .mask    (mask)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic write_mask(input logic [NSRC-1:0] m);
    cfg_we   = 1'b1;
    cfg_mask = m;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    for (int i = 0; i < budget && !ExtIRQ; i++) tick();
    chk("irq_seen", ExtIRQ, 1);
  endtask

  // waits for a request, checks its ID against the scoreboard, then acks and releases
  task automatic serve(input logic [NSRC-1:0] pend_after);
    int exp_id;
    wait_irq(20);
    chk("sb_nonempty", exp_q.size() != 0, 1);
    exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    chk("irq_id", irq_id, exp_id);
    ExtIAck = 1'b1;
    tick();
    chk("irq_drop", ExtIRQ, 0);
    chk("pend_after_ack", pending, pend_after);
    ExtIAck = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b0;
    irq_src  = '0;
    cfg_we   = 1'b0;
    cfg_mask = '0;
    ExtIAck  = 1'b0;
    tick(2);
    chk("rst_irq", ExtIRQ, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_pend", pending, 0);
    chk("rst_mask", mask, 0);
    reset = 1'b1;
    tick();

    // single event on source 3, then long-held ack
    write_mask(8'hFF);
    chk("mask_ff", mask, 8'hFF);
    irq_src[3] = 1'b1;
    exp_q.push_back(3);
    tick(2);
    chk("pend_k1", pending, 8'h00);
    tick();
    chk("pend_k2", pending, 8'h08);
    chk("irq_k2", ExtIRQ, 0);
    irq_src[3] = 1'b0;
    tick();
    chk("irq_k3", ExtIRQ, 1);
    chk("id_k3", irq_id, 3);
    tick(6);
    chk("irq_held", ExtIRQ, 1);
    chk("id_held", irq_id, exp_q[0]);
    void'(exp_q.pop_front());
    ExtIAck = 1'b1;
    tick();
    chk("ack_irq", ExtIRQ, 0);
    chk("ack_pend", pending, 8'h00);
    tick(3);
    chk("ack_hold_irq", ExtIRQ, 0);
    ExtIAck = 1'b0;
    tick(4);
    chk("no_rereq", ExtIRQ, 0);

    // priority: sources 5 and 1 together
    irq_src = 8'h22;
    exp_q.push_back(1);
    exp_q.push_back(5);
    tick(3);
    chk("pend_22", pending, 8'h22);
    irq_src = '0;
    serve(8'h20);
    serve(8'h00);

    // masking
    write_mask(8'hFB);
    irq_src[2] = 1'b1;
    exp_q.push_back(2);
    tick(3);
    irq_src[2] = 1'b0;
    chk("pend_masked", pending, 8'h04);
    tick(4);
    chk("irq_masked", ExtIRQ, 0);
    write_mask(8'hFF);
    chk("irq_mask_edge", ExtIRQ, 0);
    tick();
    chk("irq_unmasked", ExtIRQ, 1);
    serve(8'h00);

    // set-wins collision on source 4
    irq_src[4] = 1'b1;
    exp_q.push_back(4);
    tick(3);
    irq_src[4] = 1'b0;
    wait_irq(5);
    chk("coll_first_id", irq_id, exp_q.pop_front());
    tick(3);
    irq_src[4] = 1'b1;
    exp_q.push_back(4);
    tick(2);
    ExtIAck = 1'b1;
    tick();
    irq_src[4] = 1'b0;
    chk("coll_irq", ExtIRQ, 0);
    chk("coll_pend", pending, 8'h10);
    ExtIAck = 1'b0;
    serve(8'h00);

    // async reset while a request is outstanding
    irq_src[0] = 1'b1;
    tick(3);
    irq_src[0] = 1'b0;
    tick();
    chk("pre_rst_irq", ExtIRQ, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_irq", ExtIRQ, 0);
    chk("arst_pend", pending, 0);
    chk("arst_mask", mask, 0);
    tick();
    reset = 1'b1;
    tick(5);
    chk("post_rst_irq", ExtIRQ, 0);
    write_mask(8'hFF);
    tick(4);
    chk("post_mask_irq", ExtIRQ, 0);
    irq_src[6] = 1'b1;
    exp_q.push_back(6);
    tick(3);
    irq_src[6] = 1'b0;
    serve(8'h00);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised external-interrupt front end that sits directly upstream of the ARM processor top level.
- Synchronises and edge-detects NSRC asynchronous interrupt lines, latches them as pending, and applies a mask.
- Presents one interrupt at a time to the core on ExtIRQ, with a stable source ID, and retires it through the core's ExtIAck handshake.

Parameters:
- NSRC, 8, number of interrupt source lines (2..32).
- IDW, $clog2(NSRC), width of the source-ID output.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_src  input  NSRC  raw asynchronous interrupt lines; a rising edge requests service.
- cfg_we  input  1  mask-register write strobe, sampled on the clock edge.
- cfg_mask  input  NSRC  new mask value; bit=1 enables that source.
- ExtIAck  input  1  core acknowledge for the current request.
- ExtIRQ  output  1  registered interrupt request to the core.
- irq_id  output  IDW  index of the source being requested; valid while ExtIRQ=1.
- pending  output  NSRC  current pending register, for debug and test.
- mask  output  NSRC  current mask register.

Behaviour:
- Reset (reset=0, asynchronous):
  - ExtIRQ=0, irq_id=0, pending=0, mask=0.
  - Sync and edge flops cleared; FSM in IDLE.
  - Takes effect immediately, regardless of FSM state.
- Input synchronisation:
  - Two-flop synchroniser per line (s1, s2), plus a history flop s3.
  - Event = s2 & ~s3.
  - irq_src rising before edge k gives pending[i]=1 after edge k+2.
  - Level high with no new edge creates no further events.
- Pending register:
  - Set on event; cleared only when its request is acknowledged.
  - If a clear and a new event hit the same bit in the same cycle, set wins.
  - Masking never clears pending.
- Mask register:
  - mask <= cfg_mask on an edge where cfg_we=1.
  - Eligible set = pending & mask.
- Selection: fixed priority, lowest index wins.
- FSM states IDLE, REQ, WAIT_REL:
  - IDLE:
    - If the eligible set is non-zero: latch irq_id = winning index, ExtIRQ<=1, go to REQ.
    - ExtIRQ first rises one edge after pending is visible, i.e. 3 edges after the source edge.
    - ExtIAck is ignored in IDLE.
  - REQ:
    - ExtIRQ and irq_id are held stable; mask changes and new higher-priority events do not alter irq_id or drop ExtIRQ.
    - On ExtIAck=1: clear pending[irq_id] (subject to the set-wins rule), ExtIRQ<=0, go to WAIT_REL.
  - WAIT_REL:
    - ExtIRQ=0.
    - Stay until ExtIAck=0, then go to IDLE.
    - This prevents a held-high ack from retiring the next request.
- Back-to-back service:
  - With multiple eligible bits, the next request rises one edge after returning to IDLE.
  - Minimum gap with ExtIRQ low is 1 cycle after ExtIAck falls.
- irq_id holds its last value outside REQ.
- The block has no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then single event:
  - Stimulus: pulse irq_src[3] (hold 3 cycles), mask=8'hFF.
  - Response: pending=8'h08 at edge k+2; ExtIRQ=1 with irq_id=3 at edge k+3; stays asserted indefinitely until ack.
- Handshake:
  - Stimulus: in REQ, ExtIAck=1 for 4 cycles, then 0.
  - Response: ExtIRQ=0 and pending[3]=0 on the next edge; FSM stays in WAIT_REL while ack is high; no re-request.
- Priority and ordering:
  - Stimulus: raise irq_src[5] and irq_src[1] together, mask=8'hFF.
  - Response: ID 1 served first, then ID 5 after the ack release; pending goes 8'h22 -> 8'h20 -> 8'h00.
- Masking:
  - Stimulus: mask=8'hFB, event on source 2.
  - Response: pending=8'h04, ExtIRQ stays 0. Then write cfg_mask=8'hFF: ExtIRQ=1, irq_id=2 within 1 edge after the mask update.
- Set-wins collision:
  - Stimulus: time a new source-4 edge so its event coincides with the ack clear of ID 4.
  - Response: pending[4] stays 1; a second request with irq_id=4 follows.
- Async reset mid-REQ:
  - Stimulus: drive reset=0 between clock edges while ExtIRQ=1.
  - Response: ExtIRQ, pending and mask go to 0 immediately. After release, no request until a fresh source edge arrives and the mask is rewritten.
